// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: control words, op field
// values and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_serial_seq_if.sv
// Operand/result handshake bundle between a requester and the serial ALU.
interface alu_serial_seq_if #(
  parameter int WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             cout;

  modport master (
    output in_valid, a, b, alu_ctl, out_ready,
    input  in_ready, out_valid, result, zero, overflow, cout
  );

  modport slave (
    input  in_valid, a, b, alu_ctl, out_ready,
    output in_ready, out_valid, result, zero, overflow, cout
  );
endinterface

// File: rtl/alu_bit_cell.sv
// Combinational 1-bit ALU cell: optional operand inversion, AND/OR/ADD/LESS
// select, full-adder carry chain link.
module alu_bit_cell
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       ainv,
  input  logic       binv,
  input  logic       cin,
  input  logic       less,
  input  logic [1:0] op,
  output logic       res,
  output logic       cout,
  output logic       sum
);
  logic a1;
  logic b1;

  always_comb begin
    a1   = a ^ ainv;
    b1   = b ^ binv;
    sum  = a1 ^ b1 ^ cin;
    cout = (a1 & b1) | (cin & (a1 ^ b1));
    case (op)
      OP_AND:  res = a1 & b1;
      OP_OR:   res = a1 | b1;
      OP_ADD:  res = sum;
      default: res = less;
    endcase
  end
endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks one alu_bit_cell across WIDTH cycles, LSB
// first, and hands back the full-width result and flags on a valid/ready port.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNTW  = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_serial_seq_if.slave bus
);
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [3:0]       ctl_q;
  logic [CNTW-1:0]  cnt;
  logic             carry;
  logic             zero_q;
  logic             ovf_q;
  logic             cout_q;
  logic             bit_res;
  logic             bit_cout;
  logic             bit_sum;
  logic             accept;
  logic             last_bit;
  logic             ovf_nxt;

  alu_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .ainv (ctl_q[3]),
    .binv (ctl_q[2]),
    .cin  (carry),
    .less (1'b0),
    .op   (ctl_q[1:0]),
    .res  (bit_res),
    .cout (bit_cout),
    .sum  (bit_sum)
  );

  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_bit = (cnt == CNTW'(WIDTH - 1));
  // Op[1] set means ADD or SLT, the only ops where overflow is meaningful
  assign ovf_nxt  = ctl_q[1] & (carry ^ bit_cout);

  always_comb begin
    res_nxt = {bit_res, res_sh[WIDTH-1:1]};
    if (last_bit && (ctl_q[1:0] == OP_SLT)) begin
      res_nxt = {{(WIDTH-1){1'b0}}, bit_sum ^ ovf_nxt};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      ctl_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      ctl_q <= bus.alu_ctl;
      carry <= bus.alu_ctl[2];
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      carry  <= bit_cout;
      res_sh <= res_nxt;
      if (last_bit) begin
        zero_q <= (res_nxt == '0);
        ovf_q  <= ovf_nxt;
        cout_q <= bit_cout;
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_sh;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed cases plus random ops
// against a signed/unsigned arithmetic reference model.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 24;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W), .CNTW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] ctl, output logic [W-1:0] r,
                                  output logic z, output logic ov, output logic co);
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [W:0]   us;
    longint       sa;
    longint       sb;
    longint       tot;
    logic [W-1:0] low;
    a1  = ctl[3] ? ~a : a;
    b1  = ctl[2] ? ~b : b;
    us  = {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, ctl[2]};
    co  = us[W];
    sa  = a1[W-1] ? longint'(a1) - (longint'(1) << W) : longint'(a1);
    sb  = b1[W-1] ? longint'(b1) - (longint'(1) << W) : longint'(b1);
    tot = sa + sb + longint'(ctl[2]);
    low = tot[W-1:0];
    ov  = ctl[1] && ((tot > (longint'(1) << (W-1)) - 1) || (tot < -(longint'(1) << (W-1))));
    case (ctl[1:0])
      2'b00:   r = a1 & b1;
      2'b01:   r = a1 | b1;
      2'b10:   r = low;
      default: r = {{(W-1){1'b0}}, low[W-1] ^ ov};
    endcase
    z = (r == '0);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl,
                        input int hold, input string tag);
    logic [W-1:0] er;
    logic ez, eo, ec;
    int n;
    ref_alu(a, b, ctl, er, ez, eo, ec);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.alu_ctl  = ctl;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.alu_ctl  = 4'($urandom);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_val({tag, "_latency"}, 32'(n), 32'(W));
    chk_val({tag, "_result"}, 32'(bus.result), 32'(er));
    chk_val({tag, "_zero"}, 32'(bus.zero), 32'(ez));
    chk_val({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
    chk_val({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 3);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(negedge clk);
      chk_val({tag, "_hold_result"}, 32'(bus.result), 32'(er));
      chk_val({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk_val({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_val({tag, "_release_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk_val({tag, "_release_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ctl_set [6];
    checks = 0;
    errors = 0;
    ctl_set[0] = ALU_AND;
    ctl_set[1] = ALU_OR;
    ctl_set[2] = ALU_ADD;
    ctl_set[3] = ALU_SUB;
    ctl_set[4] = ALU_SLT;
    ctl_set[5] = ALU_NOR;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_ctl   = '0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_val("rst_result", 32'(bus.result), 32'd0);
    chk_val("rst_flags", {29'd0, bus.zero, bus.overflow, bus.cout}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(24'h000005, 24'h000003, ALU_ADD, 0, "add");
    run_op(24'h7FFFFF, 24'hFFFFFF, ALU_SUB, 0, "sub_ovf");
    run_op(24'h123456, 24'h123456, ALU_SUB, 0, "sub_zero");
    run_op(24'hFFFFFE, 24'h000001, ALU_SLT, 0, "slt_true");
    run_op(24'h7FFFFF, 24'h800000, ALU_SLT, 0, "slt_ovf");
    run_op(24'hF0F0F0, 24'hFF00FF, ALU_AND, 0, "and");
    run_op(24'hF0F0F0, 24'hFF00FF, ALU_OR, 0, "or");
    run_op(24'hF0F0F0, 24'hFF00FF, ALU_NOR, 0, "nor");
    run_op(24'h00ABCD, 24'h001111, ALU_ADD, 10, "backpressure");

    // reset while bit 10 is being processed
    bus.a = 24'h0FFFFF; bus.b = 24'h000001; bus.alu_ctl = ALU_ADD; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk_val("midrst_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(24'h000001, 24'h000001, ALU_ADD, 0, "after_rst");

    for (int k = 0; k < 40; k++) begin
      logic [3:0] c;
      c = (k % 8 == 7) ? 4'($urandom) : ctl_set[$urandom_range(0, 5)];
      run_op(W'($urandom), (k % 5 == 0) ? W'(0) : W'($urandom), c,
             (k % 10 == 3) ? 2 : 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
